// File: rtl/rotate_pkg.sv
// Shared types and helpers for the rotation frame-buffer bank scheduler.
package rotate_pkg;

  typedef enum logic [1:0] {
    BankFree,
    BankWriting,
    BankReady,
    BankReading
  } bank_state_t;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic {
    WrSkip,
    WrWriting
  } wr_state_t;

  function automatic int unsigned bank_base(input bank_idx_t idx, input int unsigned width,
                                            input int unsigned height);
    return {30'd0, idx} * width * height;
  endfunction

endpackage

// File: rtl/rotate_wr_addrgen.sv
// Rotated write-address generator: x/y raster counters and CW/CCW address stepping
// relative to the current bank base.
module rotate_wr_addrgen #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned AW     = 18,
  parameter int unsigned CCW    = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] base,
  input  logic          ce,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          start,
  output logic [AW-1:0] addr,
  output logic          in_range
);

  localparam int unsigned XW = $clog2(WIDTH + 1);
  localparam int unsigned YW = $clog2(HEIGHT + 1);
  localparam logic [AW-1:0] FirstOff = (CCW != 0) ? AW'(WIDTH * HEIGHT - HEIGHT)
                                                  : AW'(HEIGHT - 1);
  localparam logic [AW-1:0] PixStep  = AW'(HEIGHT);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] off_q;
  logic [AW-1:0] line_q;
  logic [AW-1:0] line_next;
  logic          hblank_q;
  logic          line_end;
  logic          y_in;

  // Line boundaries are only counted inside the active frame, so vertical-blank lines
  // do not advance y.
  assign line_end  = hblank & ~hblank_q & ~vblank;
  assign y_in      = (y_q < YW'(HEIGHT));
  assign in_range  = ce & ~hblank & ~vblank & (x_q < XW'(WIDTH)) & y_in;
  assign addr      = base + off_q;
  assign line_next = (CCW != 0) ? line_q + AW'(1) : line_q - AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      off_q    <= '0;
      line_q   <= '0;
      hblank_q <= 1'b0;
    end else begin
      hblank_q <= hblank;
      if (start) begin
        x_q    <= '0;
        y_q    <= '0;
        off_q  <= FirstOff;
        line_q <= FirstOff;
      end else if (line_end) begin
        x_q <= '0;
        if (y_in) begin
          y_q    <= y_q + YW'(1);
          line_q <= line_next;
          off_q  <= line_next;
        end
      end else if (in_range) begin
        x_q   <= x_q + XW'(1);
        off_q <= (CCW != 0) ? off_q - PixStep : off_q + PixStep;
      end
    end
  end

endmodule

// File: rtl/rotate_bank_sched.sv
// Bank scheduler for the rotation frame buffer: bank table, writer/reader hand-off and
// rotated write addressing. Define ROTATE_STATS_EN to build the drop/repeat counters.
module rotate_bank_sched
  import rotate_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned NBUF   = 3,
  parameter int unsigned AW     = 18,
  parameter int unsigned CCW    = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_ce,
  input  logic          in_hblank,
  input  logic          in_vblank,
  input  logic          out_frame_req,
  output logic [AW-1:0] wr_addr,
  output logic          wr_en,
  output logic [1:0]    wr_bank,
  output logic [AW-1:0] rd_base,
  output logic [1:0]    rd_bank,
  output logic          rd_valid,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   repeat_cnt
);

  bank_state_t   bank_q [NBUF];
  bank_state_t   bank_d [NBUF];
  wr_state_t     wr_state_q, wr_state_d;
  bank_idx_t     wr_bank_q, wr_bank_d;
  bank_idx_t     rd_bank_q, rd_bank_d;
  logic          rd_valid_q, rd_valid_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic          vblank_q;
  logic          ifb;
  logic          got_ready, got_free;
  bank_idx_t     ready_idx, free_idx;
  logic [AW-1:0] wr_base;
  logic          in_range;
`ifdef ROTATE_STATS_EN
  logic [1:0]    drop_add;
  logic          rep_inc;
`endif

  assign ifb = in_vblank & ~vblank_q;

  always_comb begin
    bank_d     = bank_q;
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_valid_d = rd_valid_q;
    rd_base_d  = rd_base_q;
    got_ready  = 1'b0;
    got_free   = 1'b0;
    ready_idx  = '0;
    free_idx   = '0;
`ifdef ROTATE_STATS_EN
    drop_add   = '0;
    rep_inc    = 1'b0;
`endif

    // Writer commit: the finished frame supersedes any READY frame nobody picked up.
    if (ifb && wr_state_q == WrWriting) begin
      for (int i = 0; i < NBUF; i++) begin
        if (bank_d[i] == BankReady) begin
          bank_d[i] = BankFree;
`ifdef ROTATE_STATS_EN
          drop_add  = drop_add + 2'd1;
`endif
        end
      end
      for (int i = 0; i < NBUF; i++) begin
        if (bank_idx_t'(i) == wr_bank_q) bank_d[i] = BankReady;
      end
    end

    // Reader step sees the commit above, so a same-cycle frame end is taken at once.
    for (int i = 0; i < NBUF; i++) begin
      if (!got_ready && bank_d[i] == BankReady) begin
        got_ready = 1'b1;
        ready_idx = bank_idx_t'(i);
      end
    end
    if (out_frame_req) begin
      if (got_ready) begin
        for (int i = 0; i < NBUF; i++) begin
          if (bank_d[i] == BankReading) bank_d[i] = BankFree;
        end
        for (int i = 0; i < NBUF; i++) begin
          if (bank_idx_t'(i) == ready_idx) bank_d[i] = BankReading;
        end
        rd_bank_d  = ready_idx;
        rd_valid_d = 1'b1;
        rd_base_d  = AW'(bank_base(ready_idx, WIDTH, HEIGHT));
      end else if (rd_valid_q) begin
`ifdef ROTATE_STATS_EN
        rep_inc = 1'b1;
`endif
      end
    end

    // Writer acquire sees banks the reader just released.
    if (ifb) begin
      for (int i = 0; i < NBUF; i++) begin
        if (!got_free && bank_d[i] == BankFree) begin
          got_free = 1'b1;
          free_idx = bank_idx_t'(i);
        end
      end
      if (got_free) begin
        for (int i = 0; i < NBUF; i++) begin
          if (bank_idx_t'(i) == free_idx) bank_d[i] = BankWriting;
        end
        wr_state_d = WrWriting;
        wr_bank_d  = free_idx;
      end else begin
        wr_state_d = WrSkip;
`ifdef ROTATE_STATS_EN
        drop_add   = drop_add + 2'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBUF; i++) bank_q[i] <= BankFree;
      wr_state_q <= WrSkip;
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_base_q  <= '0;
      vblank_q   <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_base_q  <= rd_base_d;
      vblank_q   <= in_vblank;
    end
  end

`ifdef ROTATE_STATS_EN
  logic [15:0] drop_q, rep_q;
  logic [16:0] drop_sum, rep_sum;

  assign drop_sum = {1'b0, drop_q} + {15'd0, drop_add};
  assign rep_sum  = {1'b0, rep_q} + {16'd0, rep_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      rep_q  <= '0;
    end else begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      rep_q  <= rep_sum[16] ? 16'hFFFF : rep_sum[15:0];
    end
  end

  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;
`else
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif

  assign wr_base = AW'(bank_base(wr_bank_q, WIDTH, HEIGHT));

  rotate_wr_addrgen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .AW     (AW),
    .CCW    (CCW)
  ) u_addrgen (
    .clk      (clk),
    .reset    (reset),
    .base     (wr_base),
    .ce       (in_ce),
    .hblank   (in_hblank),
    .vblank   (in_vblank),
    .start    (ifb),
    .addr     (wr_addr),
    .in_range (in_range)
  );

  assign wr_en    = in_range & (wr_state_q == WrWriting);
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign rd_valid = rd_valid_q;
  assign rd_base  = rd_base_q;

endmodule
